// File: rtl/prng_mod_draw.sv
// ---------------------------------------------------------------------------
// prng_mod_draw
// On-demand pseudorandom draw in [0, M). An xorshift generator (configurable
// triplet and width) is stepped once per draw; the stepped state is reduced
// modulo a runtime modulus either bit-serially (BPC bits per cycle, MSB first)
// or, in debias mode, by rejection sampling with a bounded retry count and a
// fallback to reduction.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   seed_i, seed_load_i     seed load (IDLE only; zero seed -> SEED_DEFAULT)
//   req_valid_i/req_ready_o draw request handshake
//   modulus_i, mode_i       modulus (0 = 2^MOD_W) and mode, sampled on accept
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_digit_o             result in [0, M)
//   rsp_fallback_o          debias ran out of retries, result from reduction
//   rsp_retries_o           rejections counted for this draw
// ---------------------------------------------------------------------------
module prng_mod_draw #(
    parameter int STATE_W                = 32,
    parameter int SH_A                   = 13,
    parameter int SH_B                   = 7,
    parameter int SH_C                   = 17,
    parameter int MOD_W                  = 4,
    parameter int BPC                    = 4,
    parameter int MAX_RETRY              = 7,
    parameter logic [STATE_W-1:0] SEED_DEFAULT = 32'h1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [STATE_W-1:0] seed_i,
    input  logic               seed_load_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [MOD_W-1:0]   modulus_i,
    input  logic               mode_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [MOD_W-1:0]   rsp_digit_o,
    output logic               rsp_fallback_o,
    output logic [7:0]         rsp_retries_o
);

    localparam int NCHUNK = STATE_W / BPC;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, STEP, REDUCE, DONE} fsm_t;

    fsm_t               fsm_reg, fsm_next;
    logic [STATE_W-1:0] state_reg;
    logic [STATE_W-1:0] shreg_reg;
    logic [MOD_W:0]     rem_reg;
    logic [MOD_W:0]     m_reg;
    logic               mode_reg;
    logic [7:0]         retries_reg;
    logic               fallback_reg;
    logic [MOD_W-1:0]   result_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               rsp_valid_reg;
    logic [MOD_W-1:0]   rsp_digit_reg;
    logic               rsp_fallback_reg;
    logic [7:0]         rsp_retries_reg;

    function automatic logic [STATE_W-1:0] xs_step(input logic [STATE_W-1:0] x);
        logic [STATE_W-1:0] y;
        y = x ^ (x << SH_A);
        y = y ^ (y >> SH_B);
        y = y ^ (y << SH_C);
        return y;
    endfunction

    logic [STATE_W-1:0] stepped;
    logic               req_ready;
    logic [MOD_W:0]     mask_v;
    logic [MOD_W:0]     candidate;
    logic               cand_ok;
    logic               retry_limit;
    logic               last_chunk;

    assign stepped     = xs_step(state_reg);
    assign req_ready   = (fsm_reg == IDLE) && !seed_load_i && !reset_i;
    assign retry_limit = (retries_reg == 8'(MAX_RETRY));
    assign last_chunk  = (cnt_reg == CNT_W'(NCHUNK - 1));

    // Smear M-1 rightwards: yields 2^K-1 with K = ceil(log2 M), i.e. the
    // narrowest all-ones mask covering every value below M (0 when M = 1).
    always_comb begin
        mask_v = m_reg - 1'b1;
        for (int i = 1; i <= MOD_W; i++) begin
            mask_v = mask_v | (mask_v >> i);
        end
    end

    assign candidate = stepped[MOD_W:0] & mask_v;
    assign cand_ok   = (candidate < m_reg);

    // Bit-serial remainder chain: r = 2r + b, conditionally subtract M.
    // Since r < M before doubling, 2r + b < 2M, so one subtraction suffices
    // and the difference fits in MOD_W+1 bits.
    logic [MOD_W:0] r_chain [0:BPC];
    assign r_chain[0] = rem_reg;

    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_red
            logic [MOD_W+1:0] dbl;
            logic [MOD_W:0]   diff;
            assign dbl  = {r_chain[gi], shreg_reg[STATE_W-1-gi]};
            assign diff = dbl[MOD_W:0] - m_reg;
            assign r_chain[gi+1] = (dbl >= {1'b0, m_reg}) ? diff : dbl[MOD_W:0];
        end
    endgenerate

    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            IDLE: begin
                if (req_valid_i && req_ready) fsm_next = STEP;
            end
            STEP: begin
                if (!mode_reg)        fsm_next = REDUCE;
                else if (cand_ok)     fsm_next = DONE;
                else if (retry_limit) fsm_next = REDUCE;
                else                  fsm_next = STEP;
            end
            REDUCE: begin
                if (last_chunk) fsm_next = DONE;
            end
            DONE: begin
                if (rsp_valid_reg && rsp_ready_i) fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fsm_reg          <= IDLE;
            state_reg        <= SEED_DEFAULT;
            shreg_reg        <= '0;
            rem_reg          <= '0;
            m_reg            <= '0;
            mode_reg         <= 1'b0;
            retries_reg      <= '0;
            fallback_reg     <= 1'b0;
            result_reg       <= '0;
            cnt_reg          <= '0;
            rsp_valid_reg    <= 1'b0;
            rsp_digit_reg    <= '0;
            rsp_fallback_reg <= 1'b0;
            rsp_retries_reg  <= '0;
        end else begin
            fsm_reg <= fsm_next;
            case (fsm_reg)
                IDLE: begin
                    if (seed_load_i) begin
                        state_reg <= (seed_i == '0) ? SEED_DEFAULT : seed_i;
                    end else if (req_valid_i) begin
                        m_reg        <= (modulus_i == '0) ? {1'b1, {MOD_W{1'b0}}}
                                                          : {1'b0, modulus_i};
                        mode_reg     <= mode_i;
                        retries_reg  <= '0;
                        fallback_reg <= 1'b0;
                    end
                end
                STEP: begin
                    state_reg <= stepped;
                    shreg_reg <= stepped;
                    rem_reg   <= '0;
                    cnt_reg   <= '0;
                    if (mode_reg) begin
                        if (cand_ok)          result_reg   <= candidate[MOD_W-1:0];
                        else if (retry_limit) fallback_reg <= 1'b1;
                        else                  retries_reg  <= retries_reg + 8'd1;
                    end
                end
                REDUCE: begin
                    shreg_reg <= shreg_reg << BPC;
                    rem_reg   <= r_chain[BPC];
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (last_chunk) result_reg <= r_chain[BPC][MOD_W-1:0];
                end
                DONE: begin
                    // First DONE cycle publishes the result; outputs then hold
                    // until the consumer takes it.
                    if (!rsp_valid_reg) begin
                        rsp_valid_reg    <= 1'b1;
                        rsp_digit_reg    <= result_reg;
                        rsp_fallback_reg <= fallback_reg;
                        rsp_retries_reg  <= retries_reg;
                    end else if (rsp_ready_i) begin
                        rsp_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o    = req_ready;
    assign rsp_valid_o    = rsp_valid_reg;
    assign rsp_digit_o    = rsp_digit_reg;
    assign rsp_fallback_o = rsp_fallback_reg;
    assign rsp_retries_o  = rsp_retries_reg;

endmodule

// File: tb/tb_prng_mod_draw.sv
// ---------------------------------------------------------------------------
// tb_prng_mod_draw
// Scoreboard bench: each draw pushes its expected response (digit, fallback,
// retries, latency); a monitor pops and compares on every response handshake
// and checks that held responses stay stable.
// ---------------------------------------------------------------------------
module tb_prng_mod_draw;

    localparam int MAX_RETRY = 7;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [31:0] seed_i = '0;
    logic        seed_load_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [3:0]  modulus_i = '0;
    logic        mode_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [3:0]  rsp_digit_o;
    logic        rsp_fallback_o;
    logic [7:0]  rsp_retries_o;

    prng_mod_draw dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .seed_i        (seed_i),
        .seed_load_i   (seed_load_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .modulus_i     (modulus_i),
        .mode_i        (mode_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_digit_o   (rsp_digit_o),
        .rsp_fallback_o(rsp_fallback_o),
        .rsp_retries_o (rsp_retries_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int digit;
        bit fb;
        int retries;
        int lat;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    longint      accept_time = 0;
    logic [31:0] st = 32'h1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    // ---------------- monitor ----------------
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [3:0] snap_digit = '0;
    logic       snap_fb = 1'b0;
    logic [7:0] snap_ret = '0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid_o && !prev_valid) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got valid=1 required valid=0");
                end else begin
                    check("latency", (($time - 7) - accept_time) / 10, sb[0].lat);
                end
            end
            if (rsp_valid_o && prev_valid && !prev_ready) begin
                check("hold_stable", {rsp_digit_o, rsp_fallback_o, rsp_retries_o},
                      {snap_digit, snap_fb, snap_ret});
            end
            if (rsp_valid_o && rsp_ready_i && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("digit", rsp_digit_o, e.digit);
                check("fallback", rsp_fallback_o, e.fb);
                check("retries", rsp_retries_o, e.retries);
                $display("[TB] draw digit=%0d fb=%0d retries=%0d", rsp_digit_o,
                         rsp_fallback_o, rsp_retries_o);
                done_cnt++;
            end
            snap_digit = rsp_digit_o;
            snap_fb    = rsp_fallback_o;
            snap_ret   = rsp_retries_o;
            prev_valid = rsp_valid_o;
            prev_ready = rsp_ready_i;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic model_draw(input int m, input bit mode, output exp_t e);
        int M, k;
        logic [31:0] cand;
        M = (m == 0) ? 16 : m;
        e.retries = 0;
        e.fb = 1'b0;
        if (!mode) begin
            st = xs(st);
            e.digit = int'(st % M);
            e.lat = 10;
        end else begin
            k = 0;
            while ((1 << k) < M) k++;
            forever begin
                st = xs(st);
                cand = st & ((32'd1 << k) - 32'd1);
                if (cand < M) begin
                    e.digit = int'(cand);
                    e.lat = 2 + e.retries;
                    break;
                end else if (e.retries == MAX_RETRY) begin
                    e.fb = 1'b1;
                    e.digit = int'(st % M);
                    e.lat = 2 + MAX_RETRY + 8;
                    break;
                end
                e.retries++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        req_valid_i = 1'b0;
        seed_load_i = 1'b0;
        rsp_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready_o, 0);
        check("rst_rsp", {rsp_valid_o, rsp_digit_o, rsp_fallback_o, rsp_retries_o}, 0);
        reset_i = 1'b0;
        st = 32'h1;
    endtask

    task automatic load_seed(input logic [31:0] s);
        @(negedge clk);
        seed_i = s;
        seed_load_i = 1'b1;
        @(negedge clk);
        seed_load_i = 1'b0;
        st = (s == 0) ? 32'h1 : s;
    endtask

    // Issue a request; returns 1 when accepted.
    task automatic issue(input int m, input bit mode, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        modulus_i = m[3:0];
        mode_i = mode;
        req_valid_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (req_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            accept_time = $time;
        end
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic draw(input int m, input bit mode, input int hold, input int hand);
        exp_t e;
        bit ok;
        int start;
        model_draw(m, mode, e);
        if (hand >= 0) e.digit = hand;
        sb.push_back(e);
        start = done_cnt;
        rsp_ready_i = (hold == 0);
        issue(m, mode, ok);
        if (!ok) begin
            check("accept_timeout", 0, 1);
            void'(sb.pop_back());
            rsp_ready_i = 1'b1;
            return;
        end
        if (hold > 0) begin
            for (int i = 0; i < 60 && !rsp_valid_o; i++) @(negedge clk);
            repeat (hold) @(negedge clk);
            rsp_ready_i = 1'b1;
        end
        for (int i = 0; i < 100 && done_cnt == start; i++) @(negedge clk);
        if (done_cnt == start) begin
            check("rsp_timeout", 0, 1);
            sb.delete();
        end
        rsp_ready_i = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] s;
        logic [31:0] t;
        bit found, ok;
        int hi;

        // Reduce m=10 from reset: state 0x40822041 -> 1082269761 mod 10 = 1.
        do_reset();
        draw(10, 1'b0, 0, 1);

        // Reduce m=7 -> 6, then debias m=7 held for 5 cycles.
        do_reset();
        draw(7, 1'b0, 0, 6);
        draw(7, 1'b1, 5, -1);

        // Zero seed falls back to the default seed.
        load_seed(32'h0);
        draw(10, 1'b0, 0, 1);

        // Seed load collides with a request: seed wins, request is refused.
        @(negedge clk);
        seed_i = 32'h1234_5678;
        seed_load_i = 1'b1;
        req_valid_i = 1'b1;
        modulus_i = 4'd10;
        mode_i = 1'b0;
        #1;
        check("seed_vs_req_ready", req_ready_o, 0);
        @(negedge clk);
        seed_load_i = 1'b0;
        req_valid_i = 1'b0;
        st = 32'h1234_5678;
        draw(10, 1'b0, 0, -1);

        // Debias m=9 with at least one rejection.
        found = 1'b0;
        s = 32'd2;
        for (int i = 0; i < 10000 && !found; i++) begin
            if ((xs(s) & 32'hF) >= 9) found = 1'b1;
            else s = s + 1;
        end
        check("search_reject_seed", found, 1);
        load_seed(s);
        draw(9, 1'b1, 0, -1);

        // Debias m=9 exhausting retries -> fallback to reduction.
        found = 1'b0;
        s = 32'd2;
        for (int i = 0; i < 100000 && !found; i++) begin
            t = s;
            hi = 0;
            for (int j = 0; j <= MAX_RETRY; j++) begin
                t = xs(t);
                if ((t & 32'hF) >= 9) hi++;
            end
            if (hi == MAX_RETRY + 1) found = 1'b1;
            else s = s + 1;
        end
        check("search_fallback_seed", found, 1);
        load_seed(s);
        draw(9, 1'b1, 0, -1);

        // Edge moduli.
        draw(1, 1'b0, 0, 0);
        draw(1, 1'b1, 0, 0);
        draw(0, 1'b0, 0, -1);
        draw(0, 1'b1, 0, -1);

        // Random draws against the model.
        for (int i = 0; i < 1000; i++) begin
            draw(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0, -1);
        end

        // Reset in the middle of REDUCE aborts the draw.
        do_reset();
        issue(10, 1'b0, ok);
        check("abort_accept", ok, 1);
        repeat (3) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid_o) hi++;
        end
        check("abort_no_rsp", hi, 0);
        st = 32'h1;
        draw(10, 1'b0, 0, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prng_mod_draw.md
Name: prng_mod_draw

Overview:
- Parametrised successor to the doorlock's xorshift PRNG and modulo reducer.
- Generates a pseudorandom value with a configurable xorshift triplet and state width, then reduces it to the range [0, m) for a runtime modulus m.
- Adds a request/response handshake and a bit-serial multi-cycle reducer in place of the wide adder tree.
- Adds an optional rejection-sampling (debias) mode with bounded retries and a reduction fallback.
- Used by the keypad scrambler to draw digit positions on demand.

Parameters:
- STATE_W, 32: xorshift state width.
- SH_A, 13: first left-shift amount.
- SH_B, 7: right-shift amount.
- SH_C, 17: second left-shift amount.
- MOD_W, 4: modulus/result width. modulus_i = 0 means 2^MOD_W.
- BPC, 4: state bits consumed per reduce cycle. Must divide STATE_W.
- MAX_RETRY, 7: rejections allowed before fallback, range 0..255.
- SEED_DEFAULT, 32'h1: reset state, and the substitute used when a zero seed is loaded.

Ports:
- clk_i, input, 1: clock.
- reset_i, input, 1: synchronous, active-high reset.
- seed_i, input, STATE_W: seed value.
- seed_load_i, input, 1: load seed_i into the state.
- req_valid_i, input, 1: draw request.
- req_ready_o, output, 1: request accepted when high together with req_valid_i.
- modulus_i, input, MOD_W: modulus m, sampled on accept.
- mode_i, input, 1: 0 = reduce, 1 = debias. Sampled on accept.
- rsp_valid_o, output, 1: result valid.
- rsp_ready_i, input, 1: consumer accepts the result.
- rsp_digit_o, output, MOD_W: result in [0, m).
- rsp_fallback_o, output, 1: debias exhausted its retries; result came from reduction.
- rsp_retries_o, output, 8: number of rejections for this draw.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on reset_i.
- Reset values:
  - state = SEED_DEFAULT; FSM = IDLE.
  - req_ready_o = 0 during reset.
  - rsp_valid_o, rsp_digit_o, rsp_fallback_o, rsp_retries_o = 0.
- Reset mid-draw aborts the draw. No response is produced, and the state returns to SEED_DEFAULT.
- Step function, applied in order:
  - x ^= x << SH_A
  - x ^= x >> SH_B (logical shift)
  - x ^= x << SH_C
- The state advances only in STEP, never while idle.
- Effective modulus M = modulus_i, or 2^MOD_W when modulus_i = 0. M is latched on accept.
- FSM states: IDLE, STEP, REDUCE, DONE.
- IDLE:
  - req_ready_o = ~seed_load_i.
  - seed_load_i has priority: state <= (seed_i == 0) ? SEED_DEFAULT : seed_i.
  - On accept (req_valid_i & req_ready_o): latch M and mode, clear the retry count, go to STEP.
  - seed_load_i is ignored in every state other than IDLE.
- STEP (one cycle):
  - state <= step(state); shift register <= step(state); remainder <= 0.
  - Reduce mode: go to REDUCE.
  - Debias mode: the candidate is the low K bits of step(state), where K = ceil(log2 M). K = 0 for M = 1, which gives candidate 0.
    - Candidate < M: result = candidate, go to DONE.
    - Candidate >= M and retries == MAX_RETRY: set fallback, go to REDUCE.
    - Otherwise: retries++ and stay in STEP, which draws a fresh state next cycle.
- REDUCE (STATE_W/BPC cycles):
  - Each cycle consumes the top BPC bits of the shift register, MSB first.
  - Per bit b: r = 2r + b; if r >= M then r -= M. Keep r at MOD_W+1 bits internally, so r < M <= 2^MOD_W always holds.
  - After the last chunk, result = r and go to DONE.
- DONE:
  - rsp_valid_o = 1; rsp_digit_o, rsp_fallback_o and rsp_retries_o are held stable.
  - On rsp_ready_i: clear rsp_valid_o and return to IDLE. The next accept is possible one cycle later (no bypass).
- Latency from the accept edge to the rsp_valid_o rising edge:
  - Reduce mode: 2 + STATE_W/BPC cycles (10 with defaults).
  - Debias mode: 2 + n cycles for n rejections.
  - Debias with fallback: 2 + MAX_RETRY + STATE_W/BPC cycles.
- Results are always exact: the reduce path equals the STATE_W-bit stepped state mod M.

Test Plan:
- Reset, then request in reduce mode with m = 10 → state becomes 0x40822041; rsp_digit_o = 1 with rsp_valid_o 10 cycles after accept; fallback = 0, retries = 0.
- Reset, then request in reduce mode with m = 7 → rsp_digit_o = 6. Then request in debias mode with m = 7 → bench model value (second state), retries as modelled. Hold rsp_ready_i = 0 for 5 cycles → outputs stay stable.
- seed_load_i with seed_i = 0 → state = SEED_DEFAULT, so the next reduce draw with m = 10 gives 1. seed_load_i asserted together with req_valid_i in IDLE → req_ready_o = 0 and the seed is loaded first.
- Debias with m = 9 from a bench-searched seed whose successor has low nibble >= 9 → retries ≥ 1 and the result matches the model.
  - With MAX_RETRY = 0 the same seed gives rsp_fallback_o = 1 and result = state mod 9.
- Edge moduli: m = 1 → 0; m = 0 (i.e. 16) → state & 0xF in both modes with no retries. 1000 random draws match the model.
- reset_i pulsed during REDUCE → no rsp_valid_o, state = SEED_DEFAULT. The following draw reproduces the first test's result.
